mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares one single-ported unified instruction/data memory between the pipeline's Fetch stage and Memory stage. It grants one requester at a time and holds the memory port for a fixed access latency. It returns read data with a one-cycle ready pulse, and the hazard logic uses the pending-but-not-ready condition to stall the pipeline. It sits between the pipelined controller/datapath and the memory model.

## Interface
Parameters:
- LATENCY, 2, memory access cycles per transaction (legal range 1..15)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- IReq  in  1  Fetch read request; held high with IAdr stable until IReady
- IAdr  in  AW  Fetch address
- IFlush  in  1  cancel the outstanding Fetch response (branch taken, PCSrcW)
- IRdata  out  DW  Fetch read data, registered
- IReady  out  1  one-cycle pulse, IRdata valid
- DReq  in  1  Memory-stage request (load or store); held with DAdr/DWe/DWdata stable until DReady
- DWe  in  1  1 = store, 0 = load
- DAdr  in  AW  data address
- DWdata  in  DW  store data
- DRdata  out  DW  load data, registered
- DReady  out  1  one-cycle pulse, access complete / DRdata valid
- MemEn  out  1  memory port enable
- MemWe  out  1  memory write enable
- MemAdr  out  AW  memory address
- MemWdata  out  DW  memory write data
- MemRdata  in  DW  memory read data, valid in the last ACCESS cycle
- Busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is pending, grant the requester and latch its address, we and wdata.
  - Load the counter with LATENCY-1, clear the cancel flag, then go to ACCESS.
  - Priority: DReq wins, except when both are pending and the previous grant was D; then I wins. This round-robin-on-conflict rule prevents fetch starvation.
- ACCESS:
  - MemEn=1, MemAdr/MemWdata come from the latched values, MemWe = owner==D and latched we.
  - The counter decrements each cycle.
  - At counter==0: capture MemRdata into IRdata or DRdata (loads/fetch only), go to RESP.
- RESP:
  - Assert IReady or DReady for the owner, unless the owner is I and the cancel flag is set.
  - Update the last-owner bit, then return to IDLE. No regrant happens in RESP.
- IFlush:
  - Sampled in ACCESS or RESP with owner I, it sets the cancel flag.
  - The memory read still completes, but IReady is suppressed and IRdata is not updated.
  - IFlush in IDLE, or with owner D, has no effect.
- Stores cannot be cancelled. A dropped DReq mid-transaction does not abort the access; DReady still pulses.
- The stored address/data come from the latch, so requester input changes after grant do not affect the access.
- Stores leave DRdata unchanged.

## Timing
- Reset (synchronous): state=IDLE, counter=0, last-owner=I, cancel=0. IRdata=0, DRdata=0, IReady=0, DReady=0, MemEn=0, MemWe=0, MemAdr=0, MemWdata=0, Busy=0.
- A request sampled high in IDLE at edge t produces:
  - ACCESS for cycles t+1..t+LATENCY;
  - RESP in cycle t+LATENCY+1, with the Ready pulse in that cycle;
  - IDLE at t+LATENCY+2.
- Throughput: one transaction per LATENCY+2 cycles. Back-to-back requests incur one IDLE cycle each.
- Store commits at the final ACCESS edge (MemWe high for all LATENCY cycles, memory writes on the last).
- Ready-data relation: Ready and data are coincident. Data holds until the next capture for the same requester.
- Reset asserted mid-ACCESS: return to IDLE on the next edge, MemEn/MemWe low from that cycle, no Ready pulse. A partially-held store must not be reported complete.
- MemEn, MemWe, Busy and the Ready pulses are decoded from registered state (no combinational path from IReq/DReq to memory pins).

## Test plan
- Single fetch, LATENCY=2: IReq=1, IAdr=0x10, memory returns 0xE3A00005 → MemEn high 2 cycles, IReady pulses in cycle 3 after grant, IRdata=0xE3A00005.
- Simultaneous IReq and DReq (load 0x80 → 0x0000_00AA) from reset → D granted first, DReady and DRdata=0xAA. I granted next, IReady follows exactly LATENCY+2 cycles after DReady.
- Continuous DReq with IReq held → grants alternate D, I, D, I; the fetch never waits more than one data transaction.
- Store DWe=1, DAdr=0x40, DWdata=0xDEADBEEF → MemWe=1 for LATENCY cycles with MemAdr=0x40, then DReady pulses. A following load of 0x40 returns 0xDEADBEEF, and DRdata is unchanged by the store itself.
- Fetch granted, IFlush pulsed in first ACCESS cycle → no IReady, IRdata keeps its old value, and the arbiter is IDLE at grant+LATENCY+2.
- Reset asserted in the second ACCESS cycle of a store → MemWe=0 and Busy=0 on the next cycle, no DReady. A pending IReq is then granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified I/D memory between the
// Fetch stage (I) and the Memory stage (D). One requester owns the port for
// LATENCY cycles, then gets a one-cycle Ready pulse with registered data.
// On a conflict D wins unless D also owned the previous grant, so fetch
// cannot be starved.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  // Fetch requester
  input  logic          IReq,
  input  logic [AW-1:0] IAdr,
  input  logic          IFlush,
  output logic [DW-1:0] IRdata,
  output logic          IReady,
  // Memory-stage requester
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAdr,
  input  logic [DW-1:0] DWdata,
  output logic [DW-1:0] DRdata,
  output logic          DReady,
  // Memory port
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAdr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          Busy
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner_d;   // 1 = current owner is the Memory stage
  logic          r_last_d;    // 1 = previous completed grant went to D
  logic          r_cancel;    // outstanding fetch response was flushed
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_irdata;
  logic [DW-1:0] r_drdata;

  logic w_any_req;
  logic w_grant_d;
  logic w_flush;

  // Grant selection: D has priority except when it also won last time and I waits.
  always_comb begin
    w_any_req = IReq | DReq;
    w_grant_d = DReq & ~(IReq & r_last_d);
    w_flush   = IFlush & ~r_owner_d;
  end

  // Arbiter FSM: grant in IDLE, hold the port in ACCESS, report in RESP.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses <= so every register sees pre-edge values;
    // datapath latches are reset too so MemAdr/MemWdata/Rdata start at zero.
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b0;
      r_cancel  <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_irdata  <= '0;
      r_drdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_adr     <= w_grant_d ? DAdr : IAdr;
            r_we      <= w_grant_d & DWe;
            r_wdata   <= w_grant_d ? DWdata : '0;
            r_cnt     <= CW'(LATENCY - 1);
            r_cancel  <= 1'b0;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_flush) r_cancel <= 1'b1;
          if (r_cnt == '0) begin
            // Capture read data on the last access cycle; a flush seen in
            // this very cycle already suppresses the fetch update.
            if (r_owner_d) begin
              if (!r_we) r_drdata <= MemRdata;
            end else if (!(r_cancel | IFlush)) begin
              r_irdata <= MemRdata;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (w_flush) r_cancel <= 1'b1;
          r_last_d <= r_owner_d;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Port and handshake outputs decoded purely from registered state.
  always_comb begin
    MemEn    = (r_state == S_ACCESS);
    MemWe    = (r_state == S_ACCESS) & r_owner_d & r_we;
    MemAdr   = r_adr;
    MemWdata = r_wdata;
    IReady   = (r_state == S_RESP) & ~r_owner_d & ~r_cancel;
    DReady   = (r_state == S_RESP) & r_owner_d;
    IRdata   = r_irdata;
    DRdata   = r_drdata;
    Busy     = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (LATENCY=2). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          IReq, IFlush, DReq, DWe;
  logic [AW-1:0] IAdr, DAdr;
  logic [DW-1:0] DWdata;
  logic [DW-1:0] IRdata, DRdata;
  logic          IReady, DReady;
  logic          MemEn, MemWe, Busy;
  logic [AW-1:0] MemAdr;
  logic [DW-1:0] MemWdata, MemRdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(LAT), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .IReq     (IReq),
    .IAdr     (IAdr),
    .IFlush   (IFlush),
    .IRdata   (IRdata),
    .IReady   (IReady),
    .DReq     (DReq),
    .DWe      (DWe),
    .DAdr     (DAdr),
    .DWdata   (DWdata),
    .DRdata   (DRdata),
    .DReady   (DReady),
    .MemEn    (MemEn),
    .MemWe    (MemWe),
    .MemAdr   (MemAdr),
    .MemWdata (MemWdata),
    .MemRdata (MemRdata),
    .Busy     (Busy)
  );

  // Memory model: combinational read, write on enabled rising edges,
  // preloaded with a few known words while reset is high.
  logic [DW-1:0] mem [0:255];
  assign MemRdata = MemEn ? mem[MemAdr[9:2]] : '0;

  always @(posedge clk) begin
    if (reset) begin
      mem[8'h04] <= 32'hE3A0_0005;  // 0x10
      mem[8'h05] <= 32'hE1A0_0000;  // 0x14
      mem[8'h06] <= 32'hE2811001;   // 0x18
      mem[8'h07] <= 32'hCAFE_F00D;  // 0x1C
      mem[8'h20] <= 32'h0000_00AA;  // 0x80
      mem[8'h21] <= 32'h1234_5678;  // 0x84
    end else if (MemEn && MemWe) begin
      mem[MemAdr[9:2]] <= MemWdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Per-cycle port/handshake check; address only checked while enabled.
  task automatic chk_cycle(input string tag, input logic en, input logic we,
                           input logic [AW-1:0] adr, input logic ir,
                           input logic dr, input logic busy);
    check({tag, ".en"},   32'(MemEn),  32'(en));
    check({tag, ".we"},   32'(MemWe),  32'(we));
    if (en) check({tag, ".adr"}, MemAdr, adr);
    check({tag, ".ir"},   32'(IReady), 32'(ir));
    check({tag, ".dr"},   32'(DReady), 32'(dr));
    check({tag, ".busy"}, 32'(Busy),   32'(busy));
  endtask

  initial begin
    reset = 1'b1; IReq = 0; IFlush = 0; DReq = 0; DWe = 0;
    IAdr = '0; DAdr = '0; DWdata = '0;
    tick(); tick();
    chk_cycle("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst.adr",    MemAdr,   32'h0);
    check("rst.wdata",  MemWdata, 32'h0);
    check("rst.irdata", IRdata,   32'h0);
    check("rst.drdata", DRdata,   32'h0);
    reset = 1'b0;
    tick();
    check("idle.busy", 32'(Busy), 32'h0);

    // 1) Single fetch of 0x10
    IReq = 1; IAdr = 32'h10;
    tick(); chk_cycle("f1.a0", 1, 0, 32'h10, 0, 0, 1);
    tick(); chk_cycle("f1.a1", 1, 0, 32'h10, 0, 0, 1);
    tick(); chk_cycle("f1.rs", 0, 0, '0, 1, 0, 1);
    check("f1.data", IRdata, 32'hE3A0_0005);
    IReq = 0;
    tick(); chk_cycle("f1.id", 0, 0, '0, 0, 0, 0);

    // 2) Conflict: D load 0x80 first, then I fetch 0x14 LAT+2 cycles later
    IReq = 1; IAdr = 32'h14; DReq = 1; DWe = 0; DAdr = 32'h80;
    tick(); chk_cycle("c.d0", 1, 0, 32'h80, 0, 0, 1);
    tick(); chk_cycle("c.d1", 1, 0, 32'h80, 0, 0, 1);
    tick(); chk_cycle("c.drs", 0, 0, '0, 0, 1, 1);
    check("c.ddata", DRdata, 32'h0000_00AA);
    DReq = 0;
    tick(); chk_cycle("c.gap", 0, 0, '0, 0, 0, 0);
    tick(); chk_cycle("c.i0", 1, 0, 32'h14, 0, 0, 1);
    tick(); chk_cycle("c.i1", 1, 0, 32'h14, 0, 0, 1);
    tick(); chk_cycle("c.irs", 0, 0, '0, 1, 0, 1);
    check("c.idata", IRdata, 32'hE1A0_0000);
    IReq = 0;
    tick();

    // 3) Both held continuously: grants alternate D, I, D, I
    IReq = 1; IAdr = 32'h18; DReq = 1; DWe = 0; DAdr = 32'h84;
    for (int j = 0; j < 4; j++) begin
      logic is_d;
      logic [AW-1:0] a;
      is_d = (j % 2 == 0);
      a = is_d ? 32'h84 : 32'h18;
      tick(); chk_cycle($sformatf("alt%0d.a0", j), 1, 0, a, 0, 0, 1);
      tick(); chk_cycle($sformatf("alt%0d.a1", j), 1, 0, a, 0, 0, 1);
      tick(); chk_cycle($sformatf("alt%0d.rs", j), 0, 0, '0, !is_d, is_d, 1);
      if (is_d) check($sformatf("alt%0d.dd", j), DRdata, 32'h1234_5678);
      else      check($sformatf("alt%0d.id", j), IRdata, 32'hE2811001);
      if (j == 3) begin IReq = 0; DReq = 0; end
      tick(); check($sformatf("alt%0d.idle", j), 32'(Busy), 32'h0);
    end

    // 4) Store 0xDEADBEEF to 0x40, then load it back
    DReq = 1; DWe = 1; DAdr = 32'h40; DWdata = 32'hDEAD_BEEF;
    tick(); chk_cycle("st.a0", 1, 1, 32'h40, 0, 0, 1);
    check("st.wdata", MemWdata, 32'hDEAD_BEEF);
    tick(); chk_cycle("st.a1", 1, 1, 32'h40, 0, 0, 1);
    tick(); chk_cycle("st.rs", 0, 0, '0, 0, 1, 1);
    check("st.drkeep", DRdata, 32'h1234_5678);
    DReq = 0; DWe = 0;
    tick();
    DReq = 1; DAdr = 32'h40;
    tick(); chk_cycle("ld.a0", 1, 0, 32'h40, 0, 0, 1);
    tick();
    tick(); chk_cycle("ld.rs", 0, 0, '0, 0, 1, 1);
    check("ld.data", DRdata, 32'hDEAD_BEEF);
    DReq = 0;
    tick();

    // 5) Fetch flushed in first ACCESS cycle
    IReq = 1; IAdr = 32'h1C;
    tick(); chk_cycle("fl.a0", 1, 0, 32'h1C, 0, 0, 1);
    IFlush = 1;
    tick(); IFlush = 0; chk_cycle("fl.a1", 1, 0, 32'h1C, 0, 0, 1);
    tick(); chk_cycle("fl.rs", 0, 0, '0, 0, 0, 1);
    check("fl.keep", IRdata, 32'hE2811001);
    IReq = 0;
    tick(); check("fl.idle", 32'(Busy), 32'h0);

    // 5b) IFlush while D owns the port has no effect
    DReq = 1; DAdr = 32'h80;
    tick(); IFlush = 1;
    tick(); IFlush = 0;
    tick(); chk_cycle("dfl.rs", 0, 0, '0, 0, 1, 1);
    check("dfl.data", DRdata, 32'h0000_00AA);
    DReq = 0;
    tick();

    // 6) Reset in second ACCESS cycle of a store, then a pending fetch
    DReq = 1; DWe = 1; DAdr = 32'h44; DWdata = 32'h55AA_55AA;
    tick(); chk_cycle("rs.a0", 1, 1, 32'h44, 0, 0, 1);
    reset = 1; DReq = 0; DWe = 0; IReq = 1; IAdr = 32'h10;
    tick(); chk_cycle("rs.after", 0, 0, '0, 0, 0, 0);
    check("rs.drdata", DRdata, 32'h0);
    reset = 0;
    tick(); chk_cycle("rs.i0", 1, 0, 32'h10, 0, 0, 1);
    tick();
    tick(); chk_cycle("rs.irs", 0, 0, '0, 1, 0, 1);
    check("rs.idata", IRdata, 32'hE3A0_0005);
    IReq = 0;
    tick(); check("rs.idle", 32'(Busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
